// File: rtl/scv_rominit_sink.sv
// Console-side ROMINIT sink: fills boot/char ROM arrays, checks order, sums images,
// and holds the console core in reset until a complete load has gone idle and settled.
module scv_rominit_sink #(
  parameter int GAP_CYCLES    = 1024,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESB,
  input  logic        ROMINIT_SEL_BOOT,
  input  logic        ROMINIT_SEL_CHR,
  input  logic [11:0] ROMINIT_ADDR,
  input  logic [7:0]  ROMINIT_DATA,
  input  logic        ROMINIT_VALID,
  input  logic [11:0] BOOT_A,
  output logic [7:0]  BOOT_DB,
  input  logic [9:0]  CHR_A,
  output logic [7:0]  CHR_DB,
  output logic        SYS_RESB,
  output logic        LOAD_ACTIVE,
  output logic        BOOT_OK,
  output logic        CHR_OK,
  output logic [15:0] BOOT_SUM,
  output logic [15:0] CHR_SUM
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic          sys_resb_q, sys_resb_d;

  logic [7:0] boot_mem [0:4095];
  logic [7:0] chr_mem  [0:1023];

  logic [12:0] boot_exp, boot_exp_n, boot_cnt, boot_cnt_n;
  logic        boot_err, boot_err_n;
  logic [15:0] boot_sum, boot_sum_n;
  logic [10:0] chr_exp, chr_exp_n, chr_cnt, chr_cnt_n;
  logic        chr_err, chr_err_n;
  logic [15:0] chr_sum, chr_sum_n;

  logic wr_boot, wr_chr, acc, restart;

  // Boot has priority when both selects are set; a strobe with no select is not a write.
  assign wr_boot = ROMINIT_VALID & ROMINIT_SEL_BOOT;
  assign wr_chr  = ROMINIT_VALID & ~ROMINIT_SEL_BOOT & ROMINIT_SEL_CHR;
  assign acc     = wr_boot | wr_chr;
  assign restart = acc & ((state == S_IDLE) | (state == S_RUN));

  always_comb begin
    boot_exp_n = restart ? 13'd0 : boot_exp;
    boot_cnt_n = restart ? 13'd0 : boot_cnt;
    boot_err_n = restart ? 1'b0  : boot_err;
    boot_sum_n = restart ? 16'd0 : boot_sum;
    chr_exp_n  = restart ? 11'd0 : chr_exp;
    chr_cnt_n  = restart ? 11'd0 : chr_cnt;
    chr_err_n  = restart ? 1'b0  : chr_err;
    chr_sum_n  = restart ? 16'd0 : chr_sum;
    if (wr_boot) begin
      if ({1'b0, ROMINIT_ADDR} == boot_exp_n) begin
        boot_exp_n = boot_exp_n + 13'd1;
        if (boot_cnt_n != 13'd4096) boot_cnt_n = boot_cnt_n + 13'd1;
      end else begin
        boot_err_n = 1'b1;
      end
      boot_sum_n = boot_sum_n + {8'h00, ROMINIT_DATA};
    end
    if (wr_chr) begin
      if ({1'b0, ROMINIT_ADDR[9:0]} == chr_exp_n) begin
        chr_exp_n = chr_exp_n + 11'd1;
        if (chr_cnt_n != 11'd1024) chr_cnt_n = chr_cnt_n + 11'd1;
      end else begin
        chr_err_n = 1'b1;
      end
      chr_sum_n = chr_sum_n + {8'h00, ROMINIT_DATA};
    end
  end

  assign BOOT_OK  = (boot_cnt == 13'd4096) & ~boot_err;
  assign CHR_OK   = (chr_cnt == 11'd1024) & ~chr_err;
  assign BOOT_SUM = boot_sum;
  assign CHR_SUM  = chr_sum;

  always_comb begin
    state_nxt  = state;
    gap_nxt    = gap_cnt;
    settle_nxt = settle_cnt;
    case (state)
      S_IDLE: if (acc) begin
        state_nxt = S_LOAD;
        gap_nxt   = '0;
      end
      S_LOAD: begin
        if (acc) begin
          gap_nxt = '0;
        end else if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_nxt  = S_SETTLE;
          settle_nxt = '0;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      S_SETTLE: begin
        if (acc) begin
          state_nxt = S_LOAD;
          gap_nxt   = '0;
        end else if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
          state_nxt = S_RUN;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      S_RUN: if (acc) begin
        state_nxt = S_LOAD;
        gap_nxt   = '0;
      end
      default: state_nxt = S_IDLE;
    endcase
    sys_resb_d = (state_nxt == S_RUN) & BOOT_OK & CHR_OK;
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state      <= S_IDLE;
      gap_cnt    <= '0;
      settle_cnt <= '0;
      sys_resb_q <= 1'b0;
      boot_exp   <= '0;
      boot_cnt   <= '0;
      boot_err   <= 1'b0;
      boot_sum   <= '0;
      chr_exp    <= '0;
      chr_cnt    <= '0;
      chr_err    <= 1'b0;
      chr_sum    <= '0;
    end else begin
      state      <= state_nxt;
      gap_cnt    <= gap_nxt;
      settle_cnt <= settle_nxt;
      sys_resb_q <= sys_resb_d;
      boot_exp   <= boot_exp_n;
      boot_cnt   <= boot_cnt_n;
      boot_err   <= boot_err_n;
      boot_sum   <= boot_sum_n;
      chr_exp    <= chr_exp_n;
      chr_cnt    <= chr_cnt_n;
      chr_err    <= chr_err_n;
      chr_sum    <= chr_sum_n;
    end
  end

  // The reload strobe must pull the core into reset before the next edge.
  assign SYS_RESB    = sys_resb_q & ~restart;
  assign LOAD_ACTIVE = (state == S_LOAD) | (state == S_SETTLE);

  always_ff @(posedge CLK) begin
    if (wr_boot) boot_mem[ROMINIT_ADDR] <= ROMINIT_DATA;
    if (wr_chr)  chr_mem[ROMINIT_ADDR[9:0]] <= ROMINIT_DATA;
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      BOOT_DB <= 8'h00;
      CHR_DB  <= 8'h00;
    end else begin
      BOOT_DB <= boot_mem[BOOT_A];
      CHR_DB  <= chr_mem[CHR_A];
    end
  end

endmodule

// File: tb/tb_scv_rominit_sink.sv
// Directed bench for scv_rominit_sink: full/partial/out-of-order loads, reload,
// combinational reset drop, read-during-write and mid-load reset.
module tb_scv_rominit_sink;
  localparam int GAP    = 1024;
  localparam int SETTLE = 16;

  logic        CLK, RESB;
  logic        ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_VALID;
  logic [11:0] ROMINIT_ADDR;
  logic [7:0]  ROMINIT_DATA;
  logic [11:0] BOOT_A;
  logic [9:0]  CHR_A;
  logic [7:0]  BOOT_DB, CHR_DB;
  logic        SYS_RESB, LOAD_ACTIVE, BOOT_OK, CHR_OK;
  logic [15:0] BOOT_SUM, CHR_SUM;

  int n_checks = 0;
  int n_fails  = 0;

  scv_rominit_sink #(.GAP_CYCLES(GAP), .SETTLE_CYCLES(SETTLE)) dut (
    .CLK(CLK), .RESB(RESB),
    .ROMINIT_SEL_BOOT(ROMINIT_SEL_BOOT), .ROMINIT_SEL_CHR(ROMINIT_SEL_CHR),
    .ROMINIT_ADDR(ROMINIT_ADDR), .ROMINIT_DATA(ROMINIT_DATA), .ROMINIT_VALID(ROMINIT_VALID),
    .BOOT_A(BOOT_A), .BOOT_DB(BOOT_DB), .CHR_A(CHR_A), .CHR_DB(CHR_DB),
    .SYS_RESB(SYS_RESB), .LOAD_ACTIVE(LOAD_ACTIVE), .BOOT_OK(BOOT_OK), .CHR_OK(CHR_OK),
    .BOOT_SUM(BOOT_SUM), .CHR_SUM(CHR_SUM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sb, input logic sc, input logic [11:0] a, input logic [7:0] d);
    @(negedge CLK);
    ROMINIT_SEL_BOOT = sb;
    ROMINIT_SEL_CHR  = sc;
    ROMINIT_ADDR     = a;
    ROMINIT_DATA     = d;
    ROMINIT_VALID    = 1'b1;
    @(posedge CLK);
    #1;
    ROMINIT_VALID = 1'b0;
  endtask

  // Starts one cycle after the last strobe's edge; SYS_RESB must still be low just
  // before gap+settle expires and must have reached its final value just after.
  task automatic settle_and_check(input string tag, input logic resb_exp);
    repeat (GAP + SETTLE - 2) @(posedge CLK);
    #1;
    chk({tag, "_resb_early"}, {15'd0, SYS_RESB}, 16'd0);
    chk({tag, "_active_early"}, {15'd0, LOAD_ACTIVE}, 16'd1);
    repeat (3) @(posedge CLK);
    #1;
    chk({tag, "_resb_run"}, {15'd0, SYS_RESB}, {15'd0, resb_exp});
    chk({tag, "_active_run"}, {15'd0, LOAD_ACTIVE}, 16'd0);
  endtask

  initial begin
    RESB = 1'b0;
    ROMINIT_SEL_BOOT = 1'b0; ROMINIT_SEL_CHR = 1'b0; ROMINIT_VALID = 1'b0;
    ROMINIT_ADDR = '0; ROMINIT_DATA = '0; BOOT_A = '0; CHR_A = '0;
    #1;
    chk("rst_sys_resb", {15'd0, SYS_RESB}, 16'd0);
    chk("rst_load_active", {15'd0, LOAD_ACTIVE}, 16'd0);
    chk("rst_boot_ok", {15'd0, BOOT_OK}, 16'd0);
    chk("rst_chr_ok", {15'd0, CHR_OK}, 16'd0);
    chk("rst_boot_sum", BOOT_SUM, 16'd0);
    chk("rst_chr_sum", CHR_SUM, 16'd0);
    chk("rst_boot_db", {8'd0, BOOT_DB}, 16'd0);
    chk("rst_chr_db", {8'd0, CHR_DB}, 16'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RESB = 1'b1;

    // Strobe with no select: stays IDLE, nothing summed
    wr(1'b0, 1'b0, 12'h000, 8'hAA);
    chk("nosel_active", {15'd0, LOAD_ACTIVE}, 16'd0);
    repeat (3) @(posedge CLK);
    #1;
    chk("nosel_active_later", {15'd0, LOAD_ACTIVE}, 16'd0);
    chk("nosel_boot_sum", BOOT_SUM, 16'd0);

    // Full load: boot data = addr[7:0] -> 16 * 0x7F80 mod 2^16 = 0xF800; chr 1024 * 0x5A = 0x6800
    for (int a = 0; a < 4096; a++) wr(1'b1, 1'b0, 12'(a), 8'(a));
    for (int a = 0; a < 1024; a++) wr(1'b0, 1'b1, 12'(a), 8'h5A);
    chk("full_boot_sum", BOOT_SUM, 16'hF800);
    chk("full_chr_sum", CHR_SUM, 16'h6800);
    chk("full_boot_ok", {15'd0, BOOT_OK}, 16'd1);
    chk("full_chr_ok", {15'd0, CHR_OK}, 16'd1);
    settle_and_check("full", 1'b1);
    @(negedge CLK);
    BOOT_A = 12'h123;
    CHR_A  = 10'h3FF;
    @(posedge CLK);
    #1;
    chk("full_boot_rd", {8'd0, BOOT_DB}, 16'h0023);
    chk("full_chr_rd", {8'd0, CHR_DB}, 16'h005A);

    // Boot stream skips 0x100 (its byte would have been 0x00, so the sum is unchanged)
    for (int a = 0; a < 4096; a++) if (a != 12'h100) wr(1'b1, 1'b0, 12'(a), 8'(a));
    for (int a = 0; a < 1024; a++) wr(1'b0, 1'b1, 12'(a), 8'h5A);
    chk("skip_boot_ok", {15'd0, BOOT_OK}, 16'd0);
    chk("skip_chr_ok", {15'd0, CHR_OK}, 16'd1);
    chk("skip_boot_sum", BOOT_SUM, 16'hF800);
    settle_and_check("skip", 1'b0);

    // Half boot image only: 8 * 0x7F80 mod 2^16 = 0xFC00
    for (int a = 0; a < 12'h800; a++) wr(1'b1, 1'b0, 12'(a), 8'(a));
    settle_and_check("half", 1'b0);
    chk("half_boot_ok", {15'd0, BOOT_OK}, 16'd0);
    chk("half_chr_ok", {15'd0, CHR_OK}, 16'd0);
    chk("half_boot_sum", BOOT_SUM, 16'hFC00);
    chk("half_chr_sum", CHR_SUM, 16'h0000);

    // Full reload with new data: 4096 * 1 = 0x1000, 1024 * 2 = 0x0800
    for (int a = 0; a < 4096; a++) wr(1'b1, 1'b0, 12'(a), 8'h01);
    for (int a = 0; a < 1024; a++) wr(1'b0, 1'b1, 12'(a), 8'h02);
    chk("reload_boot_sum", BOOT_SUM, 16'h1000);
    chk("reload_chr_sum", CHR_SUM, 16'h0800);
    settle_and_check("reload", 1'b1);
    chk("reload_boot_ok", {15'd0, BOOT_OK}, 16'd1);
    chk("reload_chr_ok", {15'd0, CHR_OK}, 16'd1);

    // Strobe in RUN: SYS_RESB drops before the edge
    @(negedge CLK);
    ROMINIT_SEL_BOOT = 1'b1; ROMINIT_SEL_CHR = 1'b0;
    ROMINIT_ADDR = 12'h000; ROMINIT_DATA = 8'h37; ROMINIT_VALID = 1'b1;
    #1;
    chk("drop_comb_resb", {15'd0, SYS_RESB}, 16'd0);
    chk("drop_comb_active", {15'd0, LOAD_ACTIVE}, 16'd0);
    @(posedge CLK);
    #1;
    ROMINIT_VALID = 1'b0;
    chk("drop_active", {15'd0, LOAD_ACTIVE}, 16'd1);
    chk("drop_resb", {15'd0, SYS_RESB}, 16'd0);
    chk("drop_boot_sum", BOOT_SUM, 16'h0037);
    chk("drop_chr_sum", CHR_SUM, 16'h0000);
    chk("drop_boot_ok", {15'd0, BOOT_OK}, 16'd0);

    // Read-during-write on chr 0x3FF: old byte first, new byte next cycle
    @(negedge CLK);
    CHR_A = 10'h3FF;
    ROMINIT_SEL_BOOT = 1'b0; ROMINIT_SEL_CHR = 1'b1;
    ROMINIT_ADDR = 12'h3FF; ROMINIT_DATA = 8'hC3; ROMINIT_VALID = 1'b1;
    @(posedge CLK);
    #1;
    ROMINIT_VALID = 1'b0;
    chk("rdw_old", {8'd0, CHR_DB}, 16'h0002);
    @(posedge CLK);
    #1;
    chk("rdw_new", {8'd0, CHR_DB}, 16'h00C3);

    // Mid-load reset pulse
    @(negedge CLK) RESB = 1'b0;
    #1;
    chk("mid_rst_active", {15'd0, LOAD_ACTIVE}, 16'd0);
    chk("mid_rst_resb", {15'd0, SYS_RESB}, 16'd0);
    chk("mid_rst_boot_sum", BOOT_SUM, 16'd0);
    chk("mid_rst_chr_sum", CHR_SUM, 16'd0);
    chk("mid_rst_boot_ok", {15'd0, BOOT_OK}, 16'd0);
    chk("mid_rst_chr_ok", {15'd0, CHR_OK}, 16'd0);
    chk("mid_rst_boot_db", {8'd0, BOOT_DB}, 16'd0);
    chk("mid_rst_chr_db", {8'd0, CHR_DB}, 16'd0);
    @(negedge CLK);
    RESB = 1'b1;
    BOOT_A = 12'h000;
    @(posedge CLK);
    #1;
    chk("mid_rst_boot0_kept", {8'd0, BOOT_DB}, 16'h0037);
    chk("mid_rst_idle", {15'd0, LOAD_ACTIVE}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
